// File: rtl/gmii_rx_frame_parser_if.sv
// Bundle of the GMII receive inputs and the parsed header, payload and status outputs
// of gmii_rx_frame_parser.
interface gmii_rx_frame_parser_if;
   logic [7:0]  gmii_rx_data_i;
   logic        gmii_rx_dv_i;
   logic        gmii_rx_er_i;
   logic        hdr_valid_o;
   logic [47:0] dst_mac_o;
   logic [47:0] src_mac_o;
   logic [15:0] eth_type_o;
   logic        pld_valid_o;
   logic [7:0]  pld_data_o;
   logic        pld_last_o;
   logic        frame_done_o;
   logic [15:0] frame_len_o;
   logic        frame_err_o;
   logic [3:0]  err_code_o;

   modport slave (
      input  gmii_rx_data_i, gmii_rx_dv_i, gmii_rx_er_i,
      output hdr_valid_o, dst_mac_o, src_mac_o, eth_type_o,
             pld_valid_o, pld_data_o, pld_last_o,
             frame_done_o, frame_len_o, frame_err_o, err_code_o
   );

   modport master (
      output gmii_rx_data_i, gmii_rx_dv_i, gmii_rx_er_i,
      input  hdr_valid_o, dst_mac_o, src_mac_o, eth_type_o,
             pld_valid_o, pld_data_o, pld_last_o,
             frame_done_o, frame_len_o, frame_err_o, err_code_o
   );
endinterface

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive front end: strips preamble/SFD, extracts DA/SA/EtherType, streams the payload
// with the FCS removed and reports per-frame status. Optional CRC-32 check: RX_FCS_CHECK_EN.
module gmii_rx_frame_parser #(
   parameter int MIN_PREAMBLE  = 1,
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518
) (
   input  logic                  gmii_rx_clk_i,
   input  logic                  gmii_rx_rst_i,
   gmii_rx_frame_parser_if.slave gmii
);
   localparam logic [3:0]  LP_MIN_PRE = 4'(MIN_PREAMBLE);
   localparam logic [15:0] LP_MIN_LEN = 16'(MIN_FRAME_LEN);
   localparam logic [15:0] LP_MAX_LEN = 16'(MAX_FRAME_LEN);

   typedef enum logic [2:0] {
      ST_WAIT_IDLE,
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_ABORT
   } state_t;

   state_t        r_state, w_state_nx;
   logic [3:0]    r_pre_cnt;
   logic [15:0]   r_len;
   logic [103:0]  r_hdr;
   logic [39:0]   r_dl;
   logic [2:0]    r_dl_cnt;
   logic          r_er, r_giant;
   logic          r_hdr_valid, r_pld_valid, r_pld_last, r_frame_done, r_frame_err;
   logic [7:0]    r_pld_data;
   logic [47:0]   r_dst_mac, r_src_mac;
   logic [15:0]   r_eth_type, r_frame_len;
   logic [3:0]    r_err_code;

   logic          w_pre_load, w_pre_inc, w_sfd, w_cnt, w_hdr_shift, w_hdr_done;
   logic          w_dl_push, w_emit, w_last, w_done;
   logic          w_giant, w_runt, w_fcs_bad;
   logic [15:0]   w_len_nx;
   logic [111:0]  w_hdr_full;
   logic [3:0]    w_err_code;

   assign w_len_nx   = (&r_len) ? r_len : r_len + 16'd1;
   assign w_giant    = (w_len_nx > LP_MAX_LEN);
   assign w_runt     = (r_len < LP_MIN_LEN);
   assign w_hdr_full = {r_hdr, gmii.gmii_rx_data_i};
   assign w_err_code = {w_fcs_bad, r_giant, w_runt, r_er};

   always_ff @(posedge gmii_rx_clk_i or posedge gmii_rx_rst_i) begin
      if (gmii_rx_rst_i) r_state <= ST_WAIT_IDLE;
      else               r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx  = r_state;
      w_pre_load  = 1'b0;
      w_pre_inc   = 1'b0;
      w_sfd       = 1'b0;
      w_cnt       = 1'b0;
      w_hdr_shift = 1'b0;
      w_hdr_done  = 1'b0;
      w_dl_push   = 1'b0;
      w_emit      = 1'b0;
      w_last      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_WAIT_IDLE: if (!gmii.gmii_rx_dv_i) w_state_nx = ST_IDLE;
         ST_IDLE: begin
            if (gmii.gmii_rx_dv_i) begin
               if (gmii.gmii_rx_data_i == 8'h55) begin
                  w_state_nx = ST_PREAMBLE;
                  w_pre_load = 1'b1;
               end else begin
                  w_state_nx = ST_WAIT_IDLE;
               end
            end
         end
         ST_PREAMBLE: begin
            if (!gmii.gmii_rx_dv_i) begin
               w_state_nx = ST_IDLE;
            end else if (gmii.gmii_rx_data_i == 8'h55) begin
               w_pre_inc = 1'b1;
            end else if (gmii.gmii_rx_data_i == 8'hD5 && r_pre_cnt >= LP_MIN_PRE) begin
               w_state_nx = ST_HEADER;
               w_sfd      = 1'b1;
            end else begin
               w_state_nx = ST_WAIT_IDLE;
            end
         end
         ST_HEADER: begin
            if (!gmii.gmii_rx_dv_i) begin
               w_state_nx = ST_IDLE;
               w_done     = 1'b1;
            end else begin
               w_cnt = 1'b1;
               if (gmii.gmii_rx_er_i) begin
                  w_state_nx = ST_ABORT;
               end else begin
                  w_hdr_shift = 1'b1;
                  if (r_len == 16'd13) begin
                     w_hdr_done = 1'b1;
                     w_state_nx = ST_PAYLOAD;
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (!gmii.gmii_rx_dv_i) begin
               // The END cycle is the registered output of this edge; IDLE is live immediately.
               w_state_nx = ST_IDLE;
               w_done     = 1'b1;
               w_last     = (r_dl_cnt == 3'd5);
            end else begin
               w_cnt = 1'b1;
               if (gmii.gmii_rx_er_i || w_giant) begin
                  w_state_nx = ST_ABORT;
               end else begin
                  w_dl_push = 1'b1;
                  w_emit    = (r_dl_cnt == 3'd5);
               end
            end
         end
         ST_ABORT: begin
            if (!gmii.gmii_rx_dv_i) begin
               w_state_nx = ST_IDLE;
               w_done     = 1'b1;
            end else begin
               w_cnt = 1'b1;
            end
         end
         default: w_state_nx = ST_WAIT_IDLE;
      endcase
   end

   always_ff @(posedge gmii_rx_clk_i or posedge gmii_rx_rst_i) begin
      if (gmii_rx_rst_i) begin
         r_pre_cnt    <= '0;
         r_len        <= '0;
         r_hdr        <= '0;
         r_dl         <= '0;
         r_dl_cnt     <= '0;
         r_er         <= 1'b0;
         r_giant      <= 1'b0;
         r_hdr_valid  <= 1'b0;
         r_pld_valid  <= 1'b0;
         r_pld_last   <= 1'b0;
         r_pld_data   <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_dst_mac    <= '0;
         r_src_mac    <= '0;
         r_eth_type   <= '0;
         r_frame_len  <= '0;
         r_err_code   <= '0;
      end else begin
         r_hdr_valid  <= w_hdr_done;
         r_pld_valid  <= w_emit | w_last;
         r_pld_last   <= w_last;
         r_frame_done <= w_done;
         if (w_emit | w_last) r_pld_data <= r_dl[39:32];
         if (w_pre_load) r_pre_cnt <= 4'd1;
         else if (w_pre_inc && r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
         if (w_sfd) begin
            r_len    <= '0;
            r_dl_cnt <= '0;
            r_er     <= 1'b0;
            r_giant  <= 1'b0;
         end else if (w_cnt) begin
            r_len <= w_len_nx;
            if (gmii.gmii_rx_er_i) r_er <= 1'b1;
            if (w_giant) r_giant <= 1'b1;
         end
         if (w_hdr_shift) r_hdr <= w_hdr_full[103:0];
         if (w_hdr_done) begin
            r_dst_mac  <= w_hdr_full[111:64];
            r_src_mac  <= w_hdr_full[63:16];
            r_eth_type <= w_hdr_full[15:0];
         end
         if (w_dl_push) begin
            r_dl <= {r_dl[31:0], gmii.gmii_rx_data_i};
            if (r_dl_cnt != 3'd5) r_dl_cnt <= r_dl_cnt + 3'd1;
         end
         if (w_done) begin
            r_frame_len <= r_len;
            r_err_code  <= w_err_code;
            r_frame_err <= |w_err_code;
         end
      end
   end

`ifdef RX_FCS_CHECK_EN
   logic [31:0] r_crc;
   logic [31:0] w_crc_rev;

   function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int unsigned i = 0; i < 8; i++)
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   always_ff @(posedge gmii_rx_clk_i or posedge gmii_rx_rst_i) begin
      if (gmii_rx_rst_i)  r_crc <= '1;
      else if (w_sfd)     r_crc <= '1;
      else if (w_cnt)     r_crc <= f_crc_byte(r_crc, gmii.gmii_rx_data_i);
   end

   // Register is LSB-first; the residue constant is in MSB-first order.
   assign w_crc_rev = {<<{r_crc}};
   assign w_fcs_bad = (w_crc_rev != 32'hC704DD7B);
`else
   assign w_fcs_bad = 1'b0;
`endif

   assign gmii.hdr_valid_o  = r_hdr_valid;
   assign gmii.dst_mac_o    = r_dst_mac;
   assign gmii.src_mac_o    = r_src_mac;
   assign gmii.eth_type_o   = r_eth_type;
   assign gmii.pld_valid_o  = r_pld_valid;
   assign gmii.pld_data_o   = r_pld_data;
   assign gmii.pld_last_o   = r_pld_last;
   assign gmii.frame_done_o = r_frame_done;
   assign gmii.frame_len_o  = r_frame_len;
   assign gmii.frame_err_o  = r_frame_err;
   assign gmii.err_code_o   = r_err_code;
endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// Scoreboard bench for gmii_rx_frame_parser: directed frames push expected header, payload
// and status entries; a negedge monitor pops and compares whatever the DUT presents.
module tb_gmii_rx_frame_parser;
   logic clk = 1'b0;
   logic rst;
   always #4 clk = ~clk;

   gmii_rx_frame_parser_if bus();

   gmii_rx_frame_parser #(
      .MIN_PREAMBLE (1),
      .MIN_FRAME_LEN(64),
      .MAX_FRAME_LEN(1518)
   ) dut (
      .gmii_rx_clk_i(clk),
      .gmii_rx_rst_i(rst),
      .gmii         (bus)
   );

`ifdef RX_FCS_CHECK_EN
   localparam logic [3:0] FCS_ERR = 4'b1000;
`else
   localparam logic [3:0] FCS_ERR = 4'b0000;
`endif
   localparam logic [111:0] HDR = 112'h102030405000_001122334400_0800;

   typedef struct packed {logic [7:0] d; logic last;} pld_t;
   typedef struct packed {logic [15:0] len; logic [3:0] code;} done_t;

   logic [111:0] q_hdr[$];
   pld_t         q_pld[$];
   done_t        q_done[$];
   int checks = 0;
   int errors = 0;

   always @(negedge clk) begin : monitor
      logic [111:0] eh;
      pld_t ep;
      done_t ed;
      if (bus.hdr_valid_o) begin
         checks++;
         if (q_hdr.size() == 0) begin
            errors++;
            $display("FAIL hdr unexpected: got %h", {bus.dst_mac_o, bus.src_mac_o, bus.eth_type_o});
         end else begin
            eh = q_hdr.pop_front();
            if ({bus.dst_mac_o, bus.src_mac_o, bus.eth_type_o} !== eh) begin
               errors++;
               $display("FAIL hdr: got %h exp %h", {bus.dst_mac_o, bus.src_mac_o, bus.eth_type_o}, eh);
            end
         end
      end
      if (bus.pld_valid_o || bus.pld_last_o) begin
         checks++;
         if (q_pld.size() == 0) begin
            errors++;
            $display("FAIL pld unexpected: got data %h last %b", bus.pld_data_o, bus.pld_last_o);
         end else begin
            ep = q_pld.pop_front();
            if (!bus.pld_valid_o || bus.pld_data_o !== ep.d || bus.pld_last_o !== ep.last) begin
               errors++;
               $display("FAIL pld: got v%b data %h last %b exp data %h last %b",
                        bus.pld_valid_o, bus.pld_data_o, bus.pld_last_o, ep.d, ep.last);
            end
         end
      end
      if (bus.frame_done_o) begin
         checks++;
         if (q_done.size() == 0) begin
            errors++;
            $display("FAIL done unexpected: got len %0d code %b", bus.frame_len_o, bus.err_code_o);
         end else begin
            ed = q_done.pop_front();
            if (bus.frame_len_o !== ed.len || bus.err_code_o !== ed.code || bus.frame_err_o !== (|ed.code)) begin
               errors++;
               $display("FAIL done: got len %0d code %b err %b exp len %0d code %b",
                        bus.frame_len_o, bus.err_code_o, bus.frame_err_o, ed.len, ed.code);
            end
         end
      end
   end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] v;
      v = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
      return v;
   endfunction

   task automatic check_zero(input string name);
      logic [208:0] outs;
      outs = {bus.hdr_valid_o, bus.dst_mac_o, bus.src_mac_o, bus.eth_type_o, bus.pld_valid_o,
              bus.pld_data_o, bus.pld_last_o, bus.frame_done_o, bus.frame_len_o,
              bus.frame_err_o, bus.err_code_o};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL %s: outputs %h exp 0", name, outs);
      end
   endtask

   task automatic exp_frame(input bit hdr, input int n, input bit last, input int flip_at,
                            input bit done, input logic [15:0] len, input logic [3:0] code);
      pld_t p;
      done_t d;
      if (hdr) q_hdr.push_back(HDR);
      for (int j = 0; j < n; j++) begin
         p.d    = 8'(j) ^ ((j == flip_at) ? 8'h01 : 8'h00);
         p.last = last && (j == n - 1);
         q_pld.push_back(p);
      end
      if (done) begin
         d.len  = len;
         d.code = code;
         q_done.push_back(d);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic dv);
      @(posedge clk); #1;
      bus.gmii_rx_data_i = d;
      bus.gmii_rx_dv_i   = dv;
      bus.gmii_rx_er_i   = 1'b0;
   endtask

   // er_at / flip_at / rst_at index payload bytes; -1 disables.
   task automatic send_frame(input int n_pre, input int n_pld, input int er_at, input bit good_fcs,
                             input int flip_at, input int gap, input int rst_at);
      logic [7:0]  f[$];
      logic [31:0] c;
      logic [111:0] h;
      h = HDR;
      f = {};
      for (int i = 13; i >= 0; i--) f.push_back(h[i*8 +: 8]);
      for (int j = 0; j < n_pld; j++) f.push_back(8'(j));
      if (good_fcs) begin
         c = 32'hFFFFFFFF;
         foreach (f[i]) c = crc_byte(c, f[i]);
         c = ~c;
         for (int k = 0; k < 4; k++) f.push_back(c[k*8 +: 8]);
      end else begin
         f.push_back(8'hEF); f.push_back(8'hBE); f.push_back(8'hAD); f.push_back(8'hDE);
      end
      if (flip_at >= 0) f[14 + flip_at] = f[14 + flip_at] ^ 8'h01;
      for (int i = 0; i < n_pre; i++) drive(8'h55, 1'b1);
      drive(8'hD5, 1'b1);
      for (int i = 0; i < f.size(); i++) begin
         @(posedge clk); #1;
         if (rst_at >= 0 && i == 14 + rst_at) rst = 1'b1;
         if (rst_at >= 0 && i == 14 + rst_at + 3) rst = 1'b0;
         bus.gmii_rx_data_i = f[i];
         bus.gmii_rx_dv_i   = 1'b1;
         bus.gmii_rx_er_i   = (er_at >= 0 && i == 14 + er_at);
         if (rst_at >= 0 && i == 14 + rst_at) begin
            #1;
            check_zero("reset_mid_frame");
         end
      end
      for (int g = 0; g < gap; g++) drive(8'h00, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.gmii_rx_data_i = '0;
      bus.gmii_rx_dv_i   = 1'b0;
      bus.gmii_rx_er_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_zero("reset_state");

      // Normal 60-byte payload, len 78
      exp_frame(1, 60, 1, -1, 1, 16'd78, 4'b0000 | FCS_ERR);
      send_frame(7, 60, -1, 0, -1, 12, -1);
      // Runt: 40-byte payload, len 58, last on 0x27
      exp_frame(1, 40, 1, -1, 1, 16'd58, 4'b0010 | FCS_ERR);
      send_frame(7, 40, -1, 0, -1, 12, -1);
      // gmii_rx_er at payload byte 10: bytes 0..4 already streamed
      exp_frame(1, 5, 0, -1, 1, 16'd78, 4'b0001 | FCS_ERR);
      send_frame(7, 60, 10, 0, -1, 12, -1);
      // Giant: byte count 1519 aborts; payload 0..1498 streamed, len 1618
      exp_frame(1, 1499, 0, -1, 1, 16'd1618, 4'b0100 | FCS_ERR);
      send_frame(7, 1600, -1, 0, -1, 12, -1);
      // Reset at payload byte 20: bytes 0..13 seen, nothing else for this frame
      exp_frame(1, 14, 0, -1, 0, 16'd0, 4'b0000);
      send_frame(7, 60, -1, 0, -1, 12, 20);
      // Normal frame after reset, then a 1-byte-preamble frame after a 1-cycle gap
      exp_frame(1, 60, 1, -1, 1, 16'd78, 4'b0000 | FCS_ERR);
      send_frame(7, 60, -1, 0, -1, 1, -1);
      exp_frame(1, 60, 1, -1, 1, 16'd78, 4'b0000 | FCS_ERR);
      send_frame(1, 60, -1, 0, -1, 12, -1);
      // SFD with no preamble: whole frame ignored
      send_frame(0, 60, -1, 0, -1, 12, -1);
      // Correct CRC, then same frame with one payload bit flipped
      exp_frame(1, 60, 1, -1, 1, 16'd78, 4'b0000);
      send_frame(7, 60, -1, 1, -1, 12, -1);
      exp_frame(1, 60, 1, 3, 1, 16'd78, FCS_ERR);
      send_frame(7, 60, -1, 1, 3, 12, -1);

      for (int t = 0; t < 50 && (q_hdr.size() + q_pld.size() + q_done.size()) != 0; t++)
         @(posedge clk);
      repeat (4) @(posedge clk);
      checks++;
      if (q_hdr.size() != 0) begin
         errors++;
         $display("FAIL hdr_missing: %0d left exp 0", q_hdr.size());
      end
      checks++;
      if (q_pld.size() != 0) begin
         errors++;
         $display("FAIL pld_missing: %0d left exp 0", q_pld.size());
      end
      checks++;
      if (q_done.size() != 0) begin
         errors++;
         $display("FAIL done_missing: %0d left exp 0", q_done.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gmii_rx_frame_parser.md
Name: gmii_rx_frame_parser

Overview:
Per-port GMII receive front end in the switch ingress path, one instance per port in the gmii_rx_clk_i domain, ahead of the clock-domain crossing into switch_clk.
- Strips preamble/SFD.
- Extracts destination MAC, source MAC and EtherType.
- Streams payload bytes with the 4-byte FCS removed.
- Reports a per-frame completion status (length, error flags) so the downstream frame writer can commit or discard.

Parameters:
MIN_PREAMBLE, 1, minimum count of 0x55 bytes required before 0xD5 SFD
MIN_FRAME_LEN, 64, minimum legal length in bytes, DA through FCS inclusive
MAX_FRAME_LEN, 1518, maximum legal length in bytes, DA through FCS inclusive

Ports:
gmii_rx_clk_i  in  1  GMII receive clock, 125 MHz; the only clock
gmii_rx_rst_i  in  1  asynchronous, active-high reset
gmii_rx_data_i  in  8  GMII receive byte
gmii_rx_dv_i  in  1  GMII data valid
gmii_rx_er_i  in  1  GMII receive error
hdr_valid_o  out  1  one-cycle pulse; header fields valid
dst_mac_o  out  48  destination MAC, first wire byte in [47:40]
src_mac_o  out  48  source MAC, first wire byte in [47:40]
eth_type_o  out  16  EtherType, first wire byte in [15:8]
pld_valid_o  out  1  payload byte strobe
pld_data_o  out  8  payload byte
pld_last_o  out  1  final payload byte of a frame with no mid-frame error
frame_done_o  out  1  one-cycle pulse at end of every frame that passed SFD
frame_len_o  out  16  bytes received from DA through FCS, saturating at 16'hFFFF
frame_err_o  out  1  OR of err_code_o, valid with frame_done_o
err_code_o  out  4  [0] gmii_er seen, [1] runt, [2] giant, [3] FCS bad

Behaviour:
- Interface: one clock (gmii_rx_clk_i); reset (gmii_rx_rst_i) is asynchronous and active-high.
- Reset: all outputs 0, dst/src/type registers 0, state WAIT_IDLE.
- States:
  - WAIT_IDLE: go to IDLE once gmii_rx_dv_i=0. A frame already in flight when reset releases is therefore ignored.
  - IDLE: on dv=1 with data=0x55, go to PREAMBLE and set preamble count to 1. On dv=1 with any other data, go to WAIT_IDLE.
  - PREAMBLE:
    - 0x55: increment preamble count, saturating at 15.
    - 0xD5 with count>=MIN_PREAMBLE: go to HEADER, clear byte count.
    - Any other byte, or 0xD5 too early: WAIT_IDLE, no frame_done.
    - dv falling: IDLE.
  - HEADER: shift in 14 bytes (DA, SA, type). On the cycle after the 14th byte is captured, pulse hdr_valid_o; fields hold until the next header. Then go to PAYLOAD.
  - PAYLOAD:
    - Bytes enter a 5-deep byte delay line.
    - Once it holds 5 bytes, each new byte pushes the oldest byte out on pld_data_o with pld_valid_o=1. The 4 newest bytes are always the FCS candidates.
  - END (cycle after dv falls):
    - If no mid-frame error and the line holds 5 bytes, emit the oldest byte with pld_valid_o=pld_last_o=1.
    - Pulse frame_done_o in the same cycle. The remaining 4 bytes are the FCS and are discarded.
    - Return to IDLE.
  - ABORT: payload suppressed; wait for dv=0, then produce the END pulse with errors, with no pld_last_o.
- dv falling in HEADER: frame_done_o with runt; hdr_valid_o is not pulsed.
- Byte count: frame_len_o counts every byte with dv=1 after the SFD.
- Runt: flagged at END if frame_len_o<MIN_FRAME_LEN. pld_last_o is still emitted if bytes were streamed; the consumer discards via frame_err_o.
- Giant: when the count exceeds MAX_FRAME_LEN, set err bit 2 and go to ABORT.
- gmii_rx_er_i=1 with dv=1 after SFD: set err bit 0 and go to ABORT.
- Latency: a payload byte appears 5 gmii_rx_clk_i cycles after it is sampled, or 1 cycle after dv falls for the final byte.
- No backpressure: downstream must accept one byte per cycle.
- Back-to-back frames: IDLE is re-entered on the END cycle, so a preamble starting 1 cycle later is accepted.

Optional Feature:
RX_FCS_CHECK_EN
- Defined: a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over DA through FCS. At END, a residue other than 0xC704DD7B sets err bit 3.
- Not defined: no CRC logic; err bit 3 is tied 0 and any FCS value is accepted.

Test Plan:
- Frame: 7x0x55, 0xD5, dst 10:20:30:40:50:00, src 00:11:22:33:44:00, type 0x0800, payload 0..59, FCS EF BE AD DE, define off. Expect hdr_valid_o once with matching fields, 60 pld_valid_o bytes 0x00..0x3B with pld_last_o on 0x3B, frame_done_o with frame_len_o=78 and err_code_o=0.
- Same frame with 40-byte payload (frame_len 58). Expect pld_last_o on byte 0x27, frame_done_o, err_code_o=4'b0010.
- gmii_rx_er_i pulsed at payload byte 10. Expect no further pld_valid_o, no pld_last_o, and at dv fall frame_done_o with err_code_o=4'b0001.
- 1600-byte payload. Expect pld_valid_o to stop once the count reaches 1519 and frame_done_o with err_code_o=4'b0100 after dv falls.
- gmii_rx_rst_i asserted for 3 cycles mid-payload. Expect outputs 0 immediately, no output for the remainder of the frame, and the next frame after 12 idle cycles parsed normally.
- With RX_FCS_CHECK_EN, a frame with correct CRC gives err_code_o=0; flipping one payload bit gives err_code_o=4'b1000.
